// File: rtl/wb_pkg.sv
// Shared definitions for the writeback scheduler: parameter defaults,
// the writeback request bundle and the arbiter priority encoding.
package wb_pkg;

  localparam int WIDTH_DEF        = 24;
  localparam int VECTOR_WIDTH_DEF = 8;
  localparam int ADDRESSWIDTH_DEF = 4;
  localparam int INDEX_WIDTH      = 3;

  typedef struct packed {
    logic [ADDRESSWIDTH_DEF-1:0]            addr;
    logic [WIDTH_DEF-1:0]                   data;
    logic [VECTOR_WIDTH_DEF*WIDTH_DEF-1:0]  data_v;
    logic                                   isvector;
    logic                                   vect_esc;
    logic [INDEX_WIDTH-1:0]                 index;
  } wb_req_t;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_t;

endpackage

// File: rtl/reg_scoreboard.sv
// One pending bit per architectural register: set on issue, cleared on
// writeback, with a set winning over a same-cycle clear of the same register.
module reg_scoreboard
  import wb_pkg::*;
#(
  parameter int ADDRESSWIDTH = ADDRESSWIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    set_en,
  input  logic [ADDRESSWIDTH-1:0] set_addr,
  input  logic                    clr_en,
  input  logic [ADDRESSWIDTH-1:0] clr_addr,
  input  logic [ADDRESSWIDTH-1:0] rd_addr_a,
  input  logic [ADDRESSWIDTH-1:0] rd_addr_b,
  input  logic [ADDRESSWIDTH-1:0] rd_addr_c,
  output logic                    rd_pend_a,
  output logic                    rd_pend_b,
  output logic                    rd_pend_c,
  output logic                    any_pending
);

  localparam int DEPTH = 2 ** ADDRESSWIDTH;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_next;

  // Clear applied first so a simultaneous set on the same register survives.
  always_comb begin
    pending_next = pending;
    if (clr_en) pending_next[clr_addr] = 1'b0;
    if (set_en) pending_next[set_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_next;
  end

  assign rd_pend_a   = pending[rd_addr_a];
  assign rd_pend_b   = pending[rd_addr_b];
  assign rd_pend_c   = pending[rd_addr_c];
  assign any_pending = |pending;

endmodule

// File: rtl/writeback_scheduler.sv
// Round-robin arbitration of ALU and memory writebacks onto a single
// registered register-file write port, plus scoreboard-based issue stalling.
module writeback_scheduler
  import wb_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF,
  parameter int ADDRESSWIDTH = ADDRESSWIDTH_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDRESSWIDTH-1:0]       alu_addr,
  input  logic [WIDTH-1:0]              alu_data,
  input  logic [VECTOR_WIDTH*WIDTH-1:0] alu_data_v,
  input  logic                          alu_isvector,
  input  logic                          alu_vect_esc,
  input  logic [2:0]                    alu_index,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDRESSWIDTH-1:0]       mem_addr,
  input  logic [WIDTH-1:0]              mem_data,
  input  logic [VECTOR_WIDTH*WIDTH-1:0] mem_data_v,
  input  logic                          mem_isvector,
  input  logic                          mem_vect_esc,
  input  logic [2:0]                    mem_index,
  input  logic                          issue_valid,
  input  logic [ADDRESSWIDTH-1:0]       issue_dest,
  input  logic [ADDRESSWIDTH-1:0]       issue_src1,
  input  logic [ADDRESSWIDTH-1:0]       issue_src2,
  output logic                          stall,
  output logic                          writeEnable,
  output logic [ADDRESSWIDTH-1:0]       writeAddress,
  output logic [WIDTH-1:0]              dataToSave,
  output logic [VECTOR_WIDTH*WIDTH-1:0] dataToSave_v,
  output logic                          isvector_A,
  output logic                          vect_esc_A,
  output logic [2:0]                    index_A,
  output logic                          idle
);

  pri_t    priority_q;
  wb_req_t sel_req;
  wb_req_t out_q;
  logic    alu_fire;
  logic    mem_fire;
  logic    pend_src1;
  logic    pend_src2;
  logic    pend_dest;
  logic    any_pending;
  logic    issue_accept;

  // A lone requester always wins; on contention the pointer decides.
  assign alu_ready = alu_valid && (!mem_valid || (priority_q == PRI_ALU));
  assign mem_ready = mem_valid && (!alu_valid || (priority_q == PRI_MEM));
  assign alu_fire  = alu_valid && alu_ready;
  assign mem_fire  = mem_valid && mem_ready;

  always_comb begin
    sel_req.addr     = alu_addr;
    sel_req.data     = alu_data;
    sel_req.data_v   = alu_data_v;
    sel_req.isvector = alu_isvector;
    sel_req.vect_esc = alu_vect_esc;
    sel_req.index    = alu_index;
    if (mem_fire) begin
      sel_req.addr     = mem_addr;
      sel_req.data     = mem_data;
      sel_req.data_v   = mem_data_v;
      sel_req.isvector = mem_isvector;
      sel_req.vect_esc = mem_vect_esc;
      sel_req.index    = mem_index;
    end
  end

  // Pointer moves to the other requester after each grant, so sustained
  // contention alternates without bubbles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      priority_q  <= PRI_ALU;
      writeEnable <= 1'b0;
      out_q       <= '0;
    end else begin
      writeEnable <= alu_fire || mem_fire;
      if (alu_fire || mem_fire) out_q <= sel_req;
      if (alu_fire)      priority_q <= PRI_MEM;
      else if (mem_fire) priority_q <= PRI_ALU;
    end
  end

  assign writeAddress = out_q.addr;
  assign dataToSave   = out_q.data;
  assign dataToSave_v = out_q.data_v;
  assign isvector_A   = out_q.isvector;
  assign vect_esc_A   = out_q.vect_esc;
  assign index_A      = out_q.index;

  reg_scoreboard #(
    .ADDRESSWIDTH (ADDRESSWIDTH)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .set_en      (issue_accept),
    .set_addr    (issue_dest),
    .clr_en      (writeEnable),
    .clr_addr    (writeAddress),
    .rd_addr_a   (issue_src1),
    .rd_addr_b   (issue_src2),
    .rd_addr_c   (issue_dest),
    .rd_pend_a   (pend_src1),
    .rd_pend_b   (pend_src2),
    .rd_pend_c   (pend_dest),
    .any_pending (any_pending)
  );

  // Checking the destination too blocks write-after-write reordering.
  assign stall        = issue_valid && (pend_src1 || pend_src2 || pend_dest);
  assign issue_accept = issue_valid && !stall;
  assign idle         = !any_pending && !writeEnable;

endmodule

// File: doc/writeback_scheduler.md
WRITEBACK_SCHEDULER -- requirements
Module: writeback_scheduler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  WIDTH  24  scalar/element data width.
  VECTOR_WIDTH  8  elements per vector register.
  ADDRESSWIDTH  4  register address width; scoreboard depth = 2**ADDRESSWIDTH.
REQ-002 Ports, one per line: name  direction  width  meaning. Clock and reset come first.
  clock  input  1  single clock; all state on rising edge.
  reset  input  1  asynchronous, active-low reset.
  alu_valid / mem_valid  input  1  writeback request from ALU / memory path.
  alu_ready / mem_ready  output  1  grant; transfer when valid && ready.
  alu_addr / mem_addr  input  ADDRESSWIDTH  destination register.
  alu_data / mem_data  input  WIDTH  scalar or element data.
  alu_data_v / mem_data_v  input  VECTOR_WIDTH x WIDTH  vector data.
  alu_isvector / mem_isvector  input  1  vector register target.
  alu_vect_esc / mem_vect_esc  input  1  single-element vector write.
  alu_index / mem_index  input  3  element index when vect_esc=1.
  issue_valid  input  1  decode wants to issue an instruction.
  issue_dest, issue_src1, issue_src2  input  ADDRESSWIDTH  instruction registers.
  stall  output  1  issue blocked this cycle.
  writeEnable  output  1  register-file write strobe (registered).
  writeAddress  output  ADDRESSWIDTH  registered write address.
  dataToSave  output  WIDTH  registered scalar/element data.
  dataToSave_v  output  VECTOR_WIDTH x WIDTH  registered vector data.
  isvector_A, vect_esc_A  output  1  registered write-mode flags.
  index_A  output  3  registered element index.
  idle  output  1  no pending registers and writeEnable=0.

Function
REQ-003 Arbiter SHALL grant at most one requester per cycle; ready is combinational from valid and priority pointer.
REQ-004 Only one valid: that requester is granted. Both valid: requester favoured by pointer is granted; pointer then flips to the other.
REQ-005 Pointer SHALL change only on a granted transfer; reset value favours ALU.
REQ-006 Granted request SHALL appear on the write-port outputs exactly one cycle after transfer, writeEnable=1 for one cycle; with no transfer writeEnable=0 and other write outputs hold their values.
REQ-007 Sustained back-to-back requests SHALL yield one write per cycle with no bubbles.
REQ-008 Scoreboard holds one pending bit per register; issue accepted when issue_valid && !stall, setting pending[issue_dest].
REQ-009 Pending bit SHALL clear on the edge ending a cycle where writeEnable=1 for that writeAddress (any mode: scalar, vector, element).
REQ-010 Same-cycle set and clear of one register: set wins.
REQ-011 stall = issue_valid && (pending[issue_src1] | pending[issue_src2] | pending[issue_dest]); combinational, covers RAW and WAW.
REQ-012 stall SHALL stay 1 during the writeEnable cycle of the awaited register and drop the following cycle.
REQ-013 Writeback to a non-pending register SHALL be written normally and leave the scoreboard unchanged.

Reset
REQ-014 reset=0 SHALL immediately clear all pending bits, writeEnable, write data/address/flags/index outputs to 0, and pointer to ALU; stall then follows REQ-011 with all pending=0.
REQ-015 Reset mid-operation SHALL discard any in-flight write; idle=1 after release.

Structure
REQ-016 Shared package wb_pkg SHALL hold the parameter defaults and struct wb_req_t {addr, data, data_v, isvector, vect_esc, index}.
REQ-017 Scoreboard SHALL be a sub-module reg_scoreboard (set port, clear port, three read ports); arbiter and output register stay in the top.

Verification
REQ-018 Reset held 3 cycles, inputs random -> all write outputs 0, stall=0 with issue_valid=0, idle=1.
REQ-019 alu_valid=1, alu_addr=3, alu_data=9 in cycle N -> alu_ready=1 in N; writeEnable=1, writeAddress=3, dataToSave=9 in N+1.
REQ-020 After reset, both valid (alu_addr=2 data 5, mem_addr=4 vector {2,1,6,4,8,4,3,2}) held -> ALU written N+1, MEM vector N+2, then ALU again N+3.
REQ-021 Issue dest=4 accepted; next issue src1=4 -> stall=1 until MEM writes reg 4; stall=0 the cycle after writeEnable, issue accepted.
REQ-022 Issue dest=3 accepted in the same cycle writeEnable=1, writeAddress=3 -> pending[3] stays 1; following issue src2=3 stalls.
REQ-023 reset=0 asserted with 2 pending registers and a granted request -> next cycle writeEnable=0, idle=1, no stall.
